// File: rtl/rv32i_types.sv
// Shared RV32I pipeline definitions: performance-counter register map,
// CTRL bit positions and the default counter window base address.
package rv32i_types;

  localparam int PERF_CTRL     = 0;
  localparam int PERF_OVF      = 1;
  localparam int PERF_CTR_BASE = 2;

  localparam int PERF_EN  = 0;
  localparam int PERF_CLR = 1;

  localparam logic [31:0] PERF_BASE_ADDR_DEFAULT = 32'hFFFF_FF80;

  // Word offset of the low half of counter i; the high half follows it.
  function automatic int perf_lo_off(input int i);
    return PERF_CTR_BASE + 2 * i;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One event counter with software preset of either 32-bit half, synchronous
// clear and wrap/saturate overflow. ovf_pulse marks an increment from all-ones.
module perf_counter #(
  parameter int CTR_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 load_lo,
  input  logic                 load_hi,
  input  logic                 clear,
  input  logic [31:0]          data,
  output logic [CTR_WIDTH-1:0] value,
  output logic                 ovf_pulse
);

  logic [CTR_WIDTH-1:0] value_q;
  logic [CTR_WIDTH-1:0] value_d;
  logic [CTR_WIDTH-1:0] hi_loaded;

  generate
    if (CTR_WIDTH > 32) begin : g_hi
      assign hi_loaded = {data[CTR_WIDTH-33:0], value_q[31:0]};
    end else begin : g_no_hi
      logic unused_hi;
      assign hi_loaded = value_q;
      assign unused_hi = load_hi;
    end
  endgenerate

  // Clear beats a software preset, which beats an event; a losing event is dropped.
  always_comb begin
    value_d   = value_q;
    ovf_pulse = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load_lo) begin
      value_d[31:0] = data;
    end else if (load_hi) begin
      value_d = hi_loaded;
    end else if (inc) begin
      if (&value_q) begin
        ovf_pulse = 1'b1;
        value_d   = SATURATE ? value_q : '0;
      end else begin
        value_d = value_q + CTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of event counters beside the MEM stage: window decode,
// CTRL/OVF registers, atomic high-word snapshot and a one-cycle response.
module perf_counter_bank
  import rv32i_types::*;
#(
  parameter int          NUM_CTRS  = 10,
  parameter int          CTR_WIDTH = 32,
  parameter bit          SATURATE  = 1'b0,
  parameter logic [31:0] BASE_ADDR = PERF_BASE_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CTRS-1:0] event_i,
  input  logic                req_read,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                sel_o,
  output logic                resp_o,
  output logic [31:0]         rdata_o,
  output logic [NUM_CTRS-1:0] ovf_o
);

  localparam int WIN_WORDS = 2 + 2 * NUM_CTRS;
  localparam int WIN_BITS  = $clog2(WIN_WORDS);

  logic [WIN_BITS-1:0] off;
  logic                wr_sel;
  logic                rd_sel;
  logic                ctrl_wr;
  logic                ovf_wr;
  logic                clr;
  logic                unused_addr;

  logic                en_q, en_d;
  logic [NUM_CTRS-1:0] ovf_q, ovf_d;
  logic                resp_q, resp_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [CTR_WIDTH-1:0] ctr_val [NUM_CTRS];
  logic [NUM_CTRS-1:0]  ovf_pulse;
  logic [31:0]          hi_word;

  assign off         = req_addr[WIN_BITS+1:2];
  assign unused_addr = ^req_addr[1:0];
  assign sel_o       = (req_addr[31:WIN_BITS+2] == BASE_ADDR[31:WIN_BITS+2]) &&
                       (req_read || req_write);

  // A simultaneous read and write is resolved as a write.
  assign wr_sel  = sel_o && req_write;
  assign rd_sel  = sel_o && req_read && !req_write;
  assign ctrl_wr = wr_sel && (off == WIN_BITS'(PERF_CTRL));
  assign ovf_wr  = wr_sel && (off == WIN_BITS'(PERF_OVF));
  assign clr     = ctrl_wr && req_wdata[PERF_CLR];

  generate
    for (genvar gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
      localparam int LO = perf_lo_off(gi);
      perf_counter #(
        .CTR_WIDTH (CTR_WIDTH),
        .SATURATE  (SATURATE)
      ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (en_q && event_i[gi]),
        .load_lo   (wr_sel && (off == WIN_BITS'(LO))),
        .load_hi   (wr_sel && (off == WIN_BITS'(LO + 1))),
        .clear     (clr),
        .data      (req_wdata),
        .value     (ctr_val[gi]),
        .ovf_pulse (ovf_pulse[gi])
      );
    end
  endgenerate

  // Reading a low word freezes that counter's upper bits so a later
  // high-word read pairs with it even if the counter has moved on.
  generate
    if (CTR_WIDTH > 32) begin : g_snap
      logic [CTR_WIDTH-33:0] hi_snap_q, hi_snap_d;

      always_comb begin
        hi_snap_d = hi_snap_q;
        for (int i = 0; i < NUM_CTRS; i++) begin
          if (rd_sel && (off == WIN_BITS'(perf_lo_off(i)))) begin
            hi_snap_d = ctr_val[i][CTR_WIDTH-1:32];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hi_snap_q <= '0;
        end else begin
          hi_snap_q <= hi_snap_d;
        end
      end

      assign hi_word = 32'(hi_snap_q);
    end else begin : g_no_snap
      assign hi_word = '0;
    end
  endgenerate

  always_comb begin
    rdata_d = '0;
    if (rd_sel) begin
      if (off == WIN_BITS'(PERF_CTRL)) begin
        rdata_d[PERF_EN] = en_q;
      end else if (off == WIN_BITS'(PERF_OVF)) begin
        rdata_d[NUM_CTRS-1:0] = ovf_q;
      end
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (off == WIN_BITS'(perf_lo_off(i))) begin
          rdata_d = ctr_val[i][31:0];
        end else if (off == WIN_BITS'(perf_lo_off(i) + 1)) begin
          rdata_d = hi_word;
        end
      end
    end
  end

  // A fresh overflow wins over a same-cycle write-1-clear of that flag.
  always_comb begin
    en_d   = ctrl_wr ? req_wdata[PERF_EN] : en_q;
    resp_d = sel_o;
    if (clr) begin
      ovf_d = '0;
    end else begin
      ovf_d = (ovf_q & ~(ovf_wr ? req_wdata[NUM_CTRS-1:0] : '0)) | ovf_pulse;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b1;
      ovf_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: three banks (64-bit wrap, 32-bit wrap, 32-bit saturate)
// share one request bus; expected read data is queued at issue time.
module tb_perf_counter_bank;

  localparam logic [31:0] BASE = 32'hFFFF_FF80;

  logic        clk;
  logic        rst_n;
  logic [3:0]  event_i;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        sel0, sel1, sel2;
  logic        resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [3:0]  ovf0, ovf1, ovf2;

  perf_counter_bank #(.NUM_CTRS(4), .CTR_WIDTH(64), .SATURATE(1'b0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .sel_o(sel0), .resp_o(resp0),
    .rdata_o(rdata0), .ovf_o(ovf0));

  perf_counter_bank #(.NUM_CTRS(4), .CTR_WIDTH(32), .SATURATE(1'b0), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .sel_o(sel1), .resp_o(resp1),
    .rdata_o(rdata1), .ovf_o(ovf1));

  perf_counter_bank #(.NUM_CTRS(4), .CTR_WIDTH(32), .SATURATE(1'b1), .BASE_ADDR(BASE)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .sel_o(sel2), .resp_o(resp2),
    .rdata_o(rdata2), .ovf_o(ovf2));

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] ev, input logic push,
                     input logic [2:0] mask, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input string tag);
    exp_t e;
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    event_i   = ev;
    if (push) begin
      e.mask = mask; e.exp0 = e0; e.exp1 = e1; e.exp2 = e2;
      e.due  = cyc + 1; e.tag = tag;
      sb_q.push_back(e);
    end
    tick();
    req_read  = 1'b0;
    req_write = 1'b0;
    event_i   = '0;
  endtask

  task automatic rd3(input int off, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input string tag);
    acc(1'b1, 1'b0, BASE + 32'(off * 4), 32'h0, 4'h0, 1'b1, 3'b111, e0, e1, e2, tag);
  endtask

  task automatic wr(input int off, input logic [31:0] wd, input logic [3:0] ev, input string tag);
    acc(1'b0, 1'b1, BASE + 32'(off * 4), wd, ev, 1'b1, 3'b000, 0, 0, 0, tag);
  endtask

  task automatic idle(input int n, input logic [3:0] ev);
    event_i = ev;
    repeat (n) tick();
    event_i = '0;
  endtask

  task automatic probe(input logic [31:0] addr, input logic exp_sel, input string tag);
    exp_t e;
    req_read = 1'b1;
    req_addr = addr;
    #1;
    chk({tag, "_sel"}, sel0, exp_sel);
    if (exp_sel) begin
      e.mask = 3'b111; e.exp0 = 0; e.exp1 = 0; e.exp2 = 0;
      e.due  = cyc + 1; e.tag = tag;
      sb_q.push_back(e);
    end
    tick();
    req_read = 1'b0;
  endtask

  // Response monitor: every selected access owes exactly one response next cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (resp0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("%s_due", e.tag), 64'(cyc), 64'(e.due));
          chk($sformatf("%s_resp12", e.tag), {resp1, resp2}, 2'b11);
          if (e.mask[0]) chk($sformatf("%s_d0", e.tag), rdata0, e.exp0);
          if (e.mask[1]) chk($sformatf("%s_d1", e.tag), rdata1, e.exp1);
          if (e.mask[2]) chk($sformatf("%s_d2", e.tag), rdata2, e.exp2);
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk($sformatf("%s_missing_resp", e.tag), 0, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; event_i = '0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Activity, then a read whose response is killed by reset.
    idle(3, 4'hF);
    req_read = 1'b1; req_addr = BASE;
    tick();
    req_read = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp", resp0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_ovf", ovf1, 0);
    tick(); tick();
    rst_n = 1'b1;

    rd3(0, 32'h1, 32'h1, 32'h1, "rst_ctrl");
    rd3(1, 0, 0, 0, "rst_ovfreg");
    rd3(2, 0, 0, 0, "rst_ctr0");

    // Counting and global enable.
    idle(7, 4'b0100);
    rd3(6, 7, 7, 7, "cnt7");
    wr(0, 32'h0, 4'h0, "en_off");
    idle(5, 4'b0100);
    rd3(6, 7, 7, 7, "cnt_hold");
    rd3(0, 0, 0, 0, "ctrl_en0");
    wr(0, 32'h1, 4'h0, "en_on");

    // Atomic high-word snapshot.
    wr(3, 32'h1, 4'h0, "preset_hi");
    wr(2, 32'hFFFF_FFFF, 4'h0, "preset_lo");
    rd3(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "snap_lo");
    idle(3, 4'b0001);
    rd3(3, 32'h1, 0, 0, "snap_hi");
    rd3(2, 32'h2, 32'h2, 32'hFFFF_FFFF, "inc_lo");
    rd3(3, 32'h2, 0, 0, "snap_hi2");

    // Overflow: wrap vs saturate.
    wr(4, 32'hFFFF_FFFF, 4'h0, "preset_c1");
    idle(1, 4'b0010);
    chk("ovf_o_d0", ovf0, 4'b0000);
    chk("ovf_o_d1", ovf1, 4'b0011);
    chk("ovf_o_d2", ovf2, 4'b0011);
    rd3(4, 0, 0, 32'hFFFF_FFFF, "ovf_lo");
    rd3(5, 32'h1, 0, 0, "ovf_hi");
    rd3(1, 0, 3, 3, "ovf_reg");
    wr(1, 32'h2, 4'h0, "ovf_w1c");
    chk("ovf_o_w1c", ovf1, 4'b0001);
    rd3(1, 0, 1, 1, "ovf_after_w1c");

    // Clear of a flag coinciding with a fresh overflow leaves it set.
    wr(8, 32'hFFFF_FFFF, 4'h0, "preset_c3");
    wr(1, 32'h8, 4'b1000, "w1c_race");
    rd3(1, 0, 9, 9, "ovf_race");

    // Priority: CLR beats events; a counter write beats an event.
    wr(0, 32'h3, 4'hF, "clr_all");
    rd3(2, 0, 0, 0, "clr_c0");
    rd3(4, 0, 0, 0, "clr_c1");
    rd3(6, 0, 0, 0, "clr_c2");
    rd3(8, 0, 0, 0, "clr_c3");
    rd3(9, 0, 0, 0, "clr_c3_hi");
    rd3(1, 0, 0, 0, "clr_ovf");
    rd3(0, 1, 1, 1, "clr_ctrl");
    wr(2, 32'h10, 4'b0001, "wr_vs_evt");
    acc(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'b0001, 1'b1, 3'b111,
        32'h10, 32'h10, 32'h10, "rd_pre_inc");
    rd3(2, 32'h11, 32'h11, 32'h11, "rd_post_inc");

    // Decode boundaries.
    probe(BASE - 32'd4, 1'b0, "below_win");
    probe(BASE + 32'd64, 1'b0, "above_win");
    probe(BASE + 32'd40, 1'b1, "unused_off10");
    probe(BASE + 32'd48, 1'b1, "unused_off12");

    idle(3, 4'h0);
    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised, memory-mapped bank of hardware event counters for the RV32I pipeline. Each counter gets a single-bit event strobe from the datapath or caches, such as branch resolved, mispredict flush, hazard stall, or L1/L2 hit/miss. Software reads, presets and clears the counters with ordinary loads and stores to a reserved address window. The bank sits beside the MEM stage: the datapath routes any data-port access whose address falls in the window here instead of to the data cache.

## Interface
Parameters:
- NUM_CTRS, 10: number of counters, 1..15.
- CTR_WIDTH, 32: counter width, 32..64.
- SATURATE, 0: overflow behaviour. 0 wraps to zero; 1 holds at all-ones.
- BASE_ADDR, 32'hFFFF_FF80: window base address. Must be aligned to the window size.

Derived: WIN_WORDS = 2 + 2*NUM_CTRS, WIN_BITS = $clog2(WIN_WORDS).

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- event_i, input, NUM_CTRS: per-counter increment strobe, one count per cycle it is high.
- req_read, input, 1: load request from the MEM stage.
- req_write, input, 1: store request from the MEM stage.
- req_addr, input, 32: byte address of the request.
- req_wdata, input, 32: store data.
- sel_o, output, 1: combinational; req_addr is inside the window. The datapath uses it to suppress the data-cache request.
- resp_o, output, 1: registered; one-cycle pulse acknowledging a selected request.
- rdata_o, output, 32: registered read data, valid while resp_o is high.
- ovf_o, output, NUM_CTRS: sticky overflow flags.

## Operation
- Decode:
  - sel_o = (req_addr[31:WIN_BITS+2] == BASE_ADDR[31:WIN_BITS+2]) && (req_read || req_write).
  - Word offset off = req_addr[WIN_BITS+1:2]. Byte enables are ignored; every access is a full word.
- Register map, by word offset:
  - 0, CTRL: bit0 EN, global count enable, reset value 1. bit1 CLR, write-1 clears all counters and ovf flags; reads as 0.
  - 1, OVF: reads return the ovf flags. Writing a 1 clears the corresponding flag.
  - 2+2i: counter i bits [31:0].
  - 3+2i: counter i bits [CTR_WIDTH-1:32].
  - Offsets at or above WIN_WORDS: reads return 0, writes are ignored. resp_o still pulses.
- Counting: when EN=1 and event_i[i]=1, counter i increments by 1. With EN=0, the counters hold.
- Overflow, on an increment from all-ones:
  - SATURATE=0: the counter becomes 0 and ovf[i] is set.
  - SATURATE=1: the counter stays all-ones and ovf[i] is set.
- Atomic 64-bit read:
  - A read of the low word of counter i also latches that counter's bits [CTR_WIDTH-1:32] into hi_snap.
  - A read of any high-word offset returns hi_snap, not the live counter.
  - If CTR_WIDTH=32, high-word reads return 0 and hi_snap is unused.
- Writes to a counter:
  - A low-word write replaces bits [31:0].
  - A high-word write replaces bits [CTR_WIDTH-1:32], truncated to width.
  - Neither write touches ovf.
- Simultaneous events, in priority order:
  - A CLR write beats a software write to a counter, which beats an event. The event in that cycle is dropped, not deferred.
  - An OVF write-1-clear and a new overflow on the same bit in the same cycle leave the flag set.
  - A read in the same cycle as an event returns the pre-increment value.
- req_read and req_write asserted together is illegal. The design treats it as a write.

## Timing
- Reset values (asynchronous, applied immediately):
  - Outputs: resp_o=0, rdata_o=0, ovf_o=0.
  - Internal state: counters=0, EN=1, hi_snap=0.
- Latency:
  - Events: an event in cycle t is visible to a read issued in cycle t+1.
  - Requests: a selected request in cycle t gives resp_o=1 and rdata_o in cycle t+1. resp_o is 0 in every other cycle.
  - Write data takes effect at the clock edge ending cycle t.
- Handshake:
  - The requester must drop the request in the cycle resp_o is high, or it issues a new access.
  - Back-to-back accesses are accepted every cycle. There is no stall path.
  - An unselected request produces no response.
- Reset asserted mid-access: a pending response is lost and resp_o goes low immediately. The requester must retry after reset.
- Wrap-around: a counter preset to all-ones takes one event to overflow. The value change and the ovf set occur at the same edge.

## Structure
- Shared package (rv32i_types) gets:
  - the register offsets (PERF_CTRL=0, PERF_OVF=1, PERF_CTR_BASE=2);
  - the CTRL bit positions (PERF_EN=0, PERF_CLR=1);
  - the default BASE_ADDR constant.
- One sub-module, perf_counter: a single CTR_WIDTH counter with inputs inc, load_lo, load_hi, clear, data and SATURATE, and outputs value and ovf_pulse. It is instantiated NUM_CTRS times with a generate loop.
- The address decode, hi_snap, read mux and response register stay in perf_counter_bank.

## Test plan
- Reset: drive rst_n low mid-stream, then read offsets 0, 1, 2 → resp_o one cycle after each read; rdata 32'h1, 0, 0.
- Counting, NUM_CTRS=4, CTR_WIDTH=64: 7 cycles of event_i[2]=1, then read offset 6 → 7. Write CTRL=0, send 5 more events, read offset 6 → still 7.
- Atomic snapshot: write 32'h1 to offset 3, then 32'hFFFF_FFFF to offset 2, so counter 0 = 64'h1_FFFF_FFFF. Read offset 2 → 32'hFFFF_FFFF, then apply 3 events, then read offset 3 → 32'h1 (snapshot, not the updated value).
- Overflow, CTR_WIDTH=32:
  - SATURATE=0: preset counter 1 to 32'hFFFF_FFFF, one event → reads 0; ovf_o[1]=1; writing 32'h2 to offset 1 clears it.
  - SATURATE=1: same stimulus → reads 32'hFFFF_FFFF; ovf_o[1]=1.
- Priority: a CLR write coinciding with events on all counters → all counters read 0 next cycle. A software write of 32'h10 to offset 2 coinciding with event_i[0] → reads 32'h10.
- Decode: access to BASE_ADDR-4, to BASE_ADDR+4*WIN_WORDS (outside the window when WIN_WORDS is a power of two), and to an unused in-window offset → sel_o=0 and no resp for the first two; the third gives sel_o=1, resp_o=1, rdata 0.
